// File: rtl/fixed_layer_bridge_pkg.sv
// fixed_layer_bridge_pkg: shared types and sizing helper for the fixed-point
// inter-layer bridge (fixed_layer_bridge, fixed_act_cast).
package fixed_layer_bridge_pkg;

   typedef enum logic [1:0] {
      ACT_NONE  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_LEAKY = 2'd2
   } act_mode_e;

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Width that holds the shifted value without loss, plus one bit so the
   // overflow test always has a sign bit above the output range.
   function automatic int cast_width(input int in_w, input int in_f,
                                     input int out_w, input int out_f);
      int diff;
      int w;
      diff = (out_f >= in_f) ? (out_f - in_f) : (in_f - out_f);
      w    = in_w + diff + 1;
      if (w < out_w + 1) w = out_w + 1;
      return w;
   endfunction

endpackage

// File: rtl/fixed_act_cast.sv
// fixed_act_cast: combinational single-element activation followed by a
// fixed-point recast. Define FIXED_LAYER_BRIDGE_SAT_EN to clamp out-of-range
// results; otherwise the low OUT_WIDTH bits are kept (two's-complement wrap).
module fixed_act_cast
   import fixed_layer_bridge_pkg::*;
#(
   parameter int IN_WIDTH       = 32,
   parameter int IN_FRAC_WIDTH  = 0,
   parameter int OUT_WIDTH      = 32,
   parameter int OUT_FRAC_WIDTH = 0,
   parameter int ACT_MODE       = 1,
   parameter int LEAKY_SHIFT    = 3
) (
   input  logic signed [IN_WIDTH-1:0]  din,
   output logic signed [OUT_WIDTH-1:0] dout
);

   localparam int CW   = cast_width(IN_WIDTH, IN_FRAC_WIDTH, OUT_WIDTH, OUT_FRAC_WIDTH);
   localparam int SH_L = (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) ? (OUT_FRAC_WIDTH - IN_FRAC_WIDTH) : 0;
   localparam int SH_R = (IN_FRAC_WIDTH > OUT_FRAC_WIDTH) ? (IN_FRAC_WIDTH - OUT_FRAC_WIDTH) : 0;

   logic signed [IN_WIDTH-1:0] act;
   logic signed [CW-1:0]       ext;
   logic signed [CW-1:0]       wide;

   // activation: only negative inputs are touched
   always_comb begin
      act = din;
      if (din[IN_WIDTH-1]) begin
         if (ACT_MODE == int'(ACT_RELU))       act = '0;
         else if (ACT_MODE == int'(ACT_LEAKY)) act = din >>> LEAKY_SHIFT;
      end
   end

   // recast: sign-extend, then align the binary point (right shift floors)
   always_comb begin
      ext  = {{(CW-IN_WIDTH){act[IN_WIDTH-1]}}, act};
      wide = (ext <<< SH_L) >>> SH_R;
   end

`ifdef FIXED_LAYER_BRIDGE_SAT_EN
   logic [CW-OUT_WIDTH:0] upper;
   logic                  fits;

   assign upper = wide[CW-1:OUT_WIDTH-1];
   assign fits  = (&upper) | ~(|upper);

   // clamp to the signed output range when the upper bits are not a pure sign run
   always_comb begin
      if (fits)              dout = wide[OUT_WIDTH-1:0];
      else if (wide[CW-1])   dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                   dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end
`else
   logic unused_hi;

   assign unused_hi = ^wide[CW-1:OUT_WIDTH];
   assign dout      = wide[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/fixed_layer_bridge.sv
// fixed_layer_bridge: registers one processed vector (activation + cast per
// element) and streams it out as IN_SIZE/OUT_SIZE chunks with a last flag.
// Accepts the next vector on the cycle the last chunk leaves, so there is no
// bubble between vectors. Saturation is selected by FIXED_LAYER_BRIDGE_SAT_EN.
module fixed_layer_bridge
   import fixed_layer_bridge_pkg::*;
#(
   parameter int IN_WIDTH       = 32,
   parameter int IN_FRAC_WIDTH  = 0,
   parameter int OUT_WIDTH      = 32,
   parameter int OUT_FRAC_WIDTH = 0,
   parameter int IN_SIZE        = 8,
   parameter int OUT_SIZE       = 2,
   parameter int ACT_MODE       = 1,
   parameter int LEAKY_SHIFT    = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE],
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   output logic signed [OUT_WIDTH-1:0] data_out [OUT_SIZE],
   output logic                        data_out_valid,
   input  logic                        data_out_ready,
   output logic                        data_out_last
);

   localparam int N     = IN_SIZE / OUT_SIZE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   state_e                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic signed [OUT_WIDTH-1:0] proc  [IN_SIZE];
   logic signed [OUT_WIDTH-1:0] buf_q [IN_SIZE];
   logic signed [OUT_WIDTH-1:0] buf_d [IN_SIZE];
   logic                        in_hs, out_hs;

   for (genvar i = 0; i < IN_SIZE; i++) begin : g_lane
      fixed_act_cast #(
         .IN_WIDTH       (IN_WIDTH),
         .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
         .OUT_WIDTH      (OUT_WIDTH),
         .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH),
         .ACT_MODE       (ACT_MODE),
         .LEAKY_SHIFT    (LEAKY_SHIFT)
      ) u_act_cast (
         .din  (data_in[i]),
         .dout (proc[i])
      );
   end

   // handshake decode; everything is held off while rst is high
   always_comb begin
      data_out_valid = !rst && (state_q == ST_STREAM);
      data_out_last  = data_out_valid && (idx_q == IDX_LAST);
      out_hs         = data_out_valid && data_out_ready;
      data_in_ready  = !rst && ((state_q == ST_EMPTY) || (out_hs && data_out_last));
      in_hs          = data_in_valid && data_in_ready;
   end

   // chunk select; zero whenever no chunk is presented
   always_comb begin
      for (int j = 0; j < OUT_SIZE; j++) data_out[j] = '0;
      if (data_out_valid) begin
         for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
               for (int j = 0; j < OUT_SIZE; j++) data_out[j] = buf_q[k*OUT_SIZE + j];
            end
         end
      end
   end

   // next state: a new vector wins over returning to EMPTY
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      if (in_hs) begin
         buf_d   = proc;
         idx_d   = '0;
         state_d = ST_STREAM;
      end else if (out_hs) begin
         if (data_out_last) begin
            idx_d   = '0;
            state_d = ST_EMPTY;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   // state, chunk index and vector buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         idx_q   <= '0;
         for (int i = 0; i < IN_SIZE; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
      end
   end

endmodule

// File: tb/tb_fixed_layer_bridge.sv
// tb_fixed_layer_bridge: directed checks of three bridge configurations
// (ReLU N=2, leaky N=1, no-activation left-shift cast N=2).
module tb_fixed_layer_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

`ifdef FIXED_LAYER_BRIDGE_SAT_EN
   localparam logic signed [3:0] A_HI = 4'sd7;
   localparam logic signed [5:0] C_LO = 6'h20;
   localparam logic signed [5:0] C_HI = 6'h1F;
`else
   localparam logic signed [3:0] A_HI = 4'hF;
   localparam logic signed [5:0] C_LO = 6'h00;
   localparam logic signed [5:0] C_HI = 6'h10;
`endif

   // A: IN 8/4 -> OUT 4/2, ReLU, 4 elements in chunks of 2
   logic signed [7:0] a_din [4];
   logic signed [3:0] a_dout [2];
   logic a_vld = 1'b0, a_irdy, a_ovld, a_ordy = 1'b0, a_last;
   // B: IN 8/4 -> OUT 8/2, leaky (>>>3), single chunk
   logic signed [7:0] b_din [4];
   logic signed [7:0] b_dout [4];
   logic b_vld = 1'b0, b_irdy, b_ovld, b_ordy = 1'b0, b_last;
   // C: IN 8/2 -> OUT 6/4, no activation, 2 elements in chunks of 1
   logic signed [7:0] c_din [2];
   logic signed [5:0] c_dout [1];
   logic c_vld = 1'b0, c_irdy, c_ovld, c_ordy = 1'b0, c_last;

   fixed_layer_bridge #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(2),
      .IN_SIZE(4), .OUT_SIZE(2), .ACT_MODE(1), .LEAKY_SHIFT(3)) u_a (
      .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_vld), .data_in_ready(a_irdy),
      .data_out(a_dout), .data_out_valid(a_ovld), .data_out_ready(a_ordy), .data_out_last(a_last));

   fixed_layer_bridge #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(2),
      .IN_SIZE(4), .OUT_SIZE(4), .ACT_MODE(2), .LEAKY_SHIFT(3)) u_b (
      .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_vld), .data_in_ready(b_irdy),
      .data_out(b_dout), .data_out_valid(b_ovld), .data_out_ready(b_ordy), .data_out_last(b_last));

   fixed_layer_bridge #(.IN_WIDTH(8), .IN_FRAC_WIDTH(2), .OUT_WIDTH(6), .OUT_FRAC_WIDTH(4),
      .IN_SIZE(2), .OUT_SIZE(1), .ACT_MODE(0), .LEAKY_SHIFT(3)) u_c (
      .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_vld), .data_in_ready(c_irdy),
      .data_out(c_dout), .data_out_valid(c_ovld), .data_out_ready(c_ordy), .data_out_last(c_last));

   task automatic load_a(input logic signed [7:0] e0, e1, e2, e3);
      a_din[0] = e0; a_din[1] = e1; a_din[2] = e2; a_din[3] = e3;
   endtask

   task automatic load_b(input logic signed [7:0] e0, e1, e2, e3);
      b_din[0] = e0; b_din[1] = e1; b_din[2] = e2; b_din[3] = e3;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== 11'b0)
         $display("FAIL reset_a: v=%b l=%b ir=%b d=[%0d,%0d] want all 0", a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]);
      else n_pass++;
      n_chk++;
      if ({b_ovld, b_last, b_irdy, c_ovld, c_last, c_irdy} !== 6'b0)
         $display("FAIL reset_bc: b v/l/ir=%b%b%b c v/l/ir=%b%b%b want 000 000", b_ovld, b_last, b_irdy, c_ovld, c_last, c_irdy);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({a_irdy, a_ovld, b_irdy, b_ovld, c_irdy, c_ovld} !== 6'b101010)
         $display("FAIL post_reset: ir/v a=%b%b b=%b%b c=%b%b want 10 10 10", a_irdy, a_ovld, b_irdy, b_ovld, c_irdy, c_ovld);
      else n_pass++;
   endtask

   task automatic test_cast_relu();
      @(posedge clk); #1;
      load_a(-8'sd16, 8'sd20, 8'sd7, 8'sd127);
      a_vld = 1'b1; a_ordy = 1'b1;
      @(negedge clk);
      n_chk++;
      if (a_irdy !== 1'b1) $display("FAIL relu_in_ready: got %b want 1", a_irdy);
      else n_pass++;
      @(posedge clk); #1;
      a_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== {3'b100, 4'sd0, 4'sd5})
         $display("FAIL relu_chunk0: v=%b l=%b ir=%b d=[%0d,%0d] want 1 0 0 [0,5]", a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== {3'b111, 4'sd1, A_HI})
         $display("FAIL relu_chunk1: v=%b l=%b ir=%b d=[%0d,%0d] want 1 1 1 [1,%0d]", a_ovld, a_last, a_irdy, a_dout[0], a_dout[1], A_HI);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (a_ovld !== 1'b0) $display("FAIL relu_drained: valid=%b want 0", a_ovld);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      @(posedge clk); #1;
      load_a(-8'sd16, 8'sd20, 8'sd7, 8'sd127);
      a_vld = 1'b1; a_ordy = 1'b0;
      @(posedge clk); #1;
      a_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== {3'b100, 4'sd0, 4'sd5})
            $display("FAIL bp_hold%0d: v=%b l=%b ir=%b d=[%0d,%0d] want 1 0 0 [0,5]", i, a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]);
         else n_pass++;
      end
      @(posedge clk); #1;
      a_ordy = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_dout[0], a_dout[1]} !== {2'b10, 4'sd0, 4'sd5})
         $display("FAIL bp_release0: v=%b l=%b d=[%0d,%0d] want 1 0 [0,5]", a_ovld, a_last, a_dout[0], a_dout[1]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_dout[0], a_dout[1]} !== {2'b11, 4'sd1, A_HI})
         $display("FAIL bp_release1: v=%b l=%b d=[%0d,%0d] want 1 1 [1,%0d]", a_ovld, a_last, a_dout[0], a_dout[1], A_HI);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (a_ovld !== 1'b0) $display("FAIL bp_drained: valid=%b want 0", a_ovld);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      load_a(-8'sd16, 8'sd20, 8'sd7, 8'sd127);
      a_vld = 1'b1; a_ordy = 1'b1;
      @(posedge clk); #1;
      load_a(8'sd8, -8'sd40, 8'sd24, 8'sd12);
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== {3'b100, 4'sd0, 4'sd5})
         $display("FAIL b2b_v1c0: v=%b l=%b ir=%b d=[%0d,%0d] want 1 0 0 [0,5]", a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== {3'b111, 4'sd1, A_HI})
         $display("FAIL b2b_v1c1: v=%b l=%b ir=%b d=[%0d,%0d] want 1 1 1 [1,%0d]", a_ovld, a_last, a_irdy, a_dout[0], a_dout[1], A_HI);
      else n_pass++;
      @(posedge clk); #1;
      a_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_dout[0], a_dout[1]} !== {2'b10, 4'sd2, 4'sd0})
         $display("FAIL b2b_v2c0: v=%b l=%b d=[%0d,%0d] want 1 0 [2,0]", a_ovld, a_last, a_dout[0], a_dout[1]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_dout[0], a_dout[1]} !== {2'b11, 4'sd6, 4'sd3})
         $display("FAIL b2b_v2c1: v=%b l=%b d=[%0d,%0d] want 1 1 [6,3]", a_ovld, a_last, a_dout[0], a_dout[1]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (a_ovld !== 1'b0) $display("FAIL b2b_drained: valid=%b want 0", a_ovld);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      @(posedge clk); #1;
      load_a(8'sd8, -8'sd40, 8'sd24, 8'sd12);
      a_vld = 1'b1; a_ordy = 1'b1;
      @(posedge clk); #1;
      a_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_dout[0], a_dout[1]} !== {1'b1, 4'sd2, 4'sd0})
         $display("FAIL mid_chunk0: v=%b d=[%0d,%0d] want 1 [2,0]", a_ovld, a_dout[0], a_dout[1]);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]} !== 11'b0)
         $display("FAIL mid_in_reset: v=%b l=%b ir=%b d=[%0d,%0d] want all 0", a_ovld, a_last, a_irdy, a_dout[0], a_dout[1]);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_irdy, a_dout[0], a_dout[1]} !== {2'b01, 8'h00})
         $display("FAIL mid_after_reset: v=%b ir=%b d=[%0d,%0d] want 0 1 [0,0]", a_ovld, a_irdy, a_dout[0], a_dout[1]);
      else n_pass++;
      @(posedge clk); #1;
      load_a(-8'sd16, 8'sd20, 8'sd7, 8'sd127);
      a_vld = 1'b1;
      @(posedge clk); #1;
      a_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_dout[0], a_dout[1]} !== {2'b10, 4'sd0, 4'sd5})
         $display("FAIL mid_new_c0: v=%b l=%b d=[%0d,%0d] want 1 0 [0,5]", a_ovld, a_last, a_dout[0], a_dout[1]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({a_ovld, a_last, a_dout[0], a_dout[1]} !== {2'b11, 4'sd1, A_HI})
         $display("FAIL mid_new_c1: v=%b l=%b d=[%0d,%0d] want 1 1 [1,%0d]", a_ovld, a_last, a_dout[0], a_dout[1], A_HI);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_leaky_single_chunk();
      @(posedge clk); #1;
      load_b(-8'sd64, 8'sd100, -8'sd128, 8'sd127);
      b_vld = 1'b1; b_ordy = 1'b1;
      @(posedge clk); #1;
      load_b(8'sd0, -8'sd1, -8'sd8, 8'sd16);
      @(negedge clk);
      n_chk++;
      if ({b_ovld, b_last, b_irdy, b_dout[0], b_dout[1], b_dout[2], b_dout[3]} !== {3'b111, 32'hFE19FC1F})
         $display("FAIL leaky_v1: v=%b l=%b ir=%b d=[%0d,%0d,%0d,%0d] want 1 1 1 [-2,25,-4,31]",
                  b_ovld, b_last, b_irdy, b_dout[0], b_dout[1], b_dout[2], b_dout[3]);
      else n_pass++;
      @(posedge clk); #1;
      b_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({b_ovld, b_last, b_dout[0], b_dout[1], b_dout[2], b_dout[3]} !== {2'b11, 32'h00FFFF04})
         $display("FAIL leaky_v2: v=%b l=%b d=[%0d,%0d,%0d,%0d] want 1 1 [0,-1,-1,4]",
                  b_ovld, b_last, b_dout[0], b_dout[1], b_dout[2], b_dout[3]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (b_ovld !== 1'b0) $display("FAIL leaky_drained: valid=%b want 0", b_ovld);
      else n_pass++;
   endtask

   task automatic test_cast_range();
      @(posedge clk); #1;
      c_din[0] = -8'sd128; c_din[1] = 8'sd100;
      c_vld = 1'b1; c_ordy = 1'b1;
      @(posedge clk); #1;
      c_din[0] = 8'sd5; c_din[1] = -8'sd3;
      @(negedge clk);
      n_chk++;
      if ({c_ovld, c_last, c_irdy, c_dout[0]} !== {3'b100, C_LO})
         $display("FAIL range_lo: v=%b l=%b ir=%b d=%0d want 1 0 0 %0d", c_ovld, c_last, c_irdy, c_dout[0], C_LO);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({c_ovld, c_last, c_irdy, c_dout[0]} !== {3'b111, C_HI})
         $display("FAIL range_hi: v=%b l=%b ir=%b d=%0d want 1 1 1 %0d", c_ovld, c_last, c_irdy, c_dout[0], C_HI);
      else n_pass++;
      @(posedge clk); #1;
      c_vld = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({c_ovld, c_last, c_dout[0]} !== {2'b10, 6'h14})
         $display("FAIL range_in0: v=%b l=%b d=%0d want 1 0 20", c_ovld, c_last, c_dout[0]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({c_ovld, c_last, c_dout[0]} !== {2'b11, 6'h34})
         $display("FAIL range_in1: v=%b l=%b d=%0d want 1 1 -12", c_ovld, c_last, c_dout[0]);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (c_ovld !== 1'b0) $display("FAIL range_drained: valid=%b want 0", c_ovld);
      else n_pass++;
   endtask

   initial begin
      load_a(8'sd0, 8'sd0, 8'sd0, 8'sd0);
      load_b(8'sd0, 8'sd0, 8'sd0, 8'sd0);
      c_din[0] = 8'sd0; c_din[1] = 8'sd0;
      test_reset();
      test_cast_relu();
      test_back_pressure();
      test_back_to_back();
      test_reset_midstream();
      test_leaky_single_chunk();
      test_cast_range();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
